// File: rtl/dither_pack_pkg.sv
// Shared constants and elaboration helpers for the dither output packer.
package dither_pack_pkg;

    localparam int unsigned PIX_W        = 4;
    localparam int unsigned PIX_PER_BEAT = 4;
    localparam int unsigned BEAT_W       = 16;
    localparam int unsigned BPP_MIN      = 1;
    localparam int unsigned BPP_MAX      = 2;

    function automatic bit bpp_legal(input int unsigned bpp);
        return (bpp >= BPP_MIN) && (bpp <= BPP_MAX);
    endfunction

    // A word must hold a whole number of beats and more than one beat.
    function automatic bit out_w_legal(input int unsigned bpp, input int unsigned out_w);
        if (bpp == 0) return 1'b0;
        return ((out_w % (PIX_PER_BEAT * bpp)) == 0) && (out_w > PIX_PER_BEAT * bpp);
    endfunction

endpackage

// File: rtl/dither_pack_if.sv
// Pixel-beat input stream and packed-word output stream of the packer.
interface dither_pack_if #(
    parameter int unsigned OUT_W = 32
) ();
    import dither_pack_pkg::*;

    logic [BEAT_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic              invert;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output in_data, in_valid, in_last, invert, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, invert, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

endinterface

// File: rtl/pix_quant.sv
// Combinational quantizer: keeps the top BPP bits of a dithered pixel, optionally inverted.
module pix_quant
    import dither_pack_pkg::*;
#(
    parameter int unsigned BPP = 1
) (
    input  logic [PIX_W-1:0] i_p,
    input  logic             i_invert,
    output logic [BPP-1:0]   o_q_c
);

    logic [BPP-1:0] w_q;
    logic           w_unused_lsbs;

    assign w_q           = i_p[PIX_W-1 -: BPP];
    assign o_q_c         = i_invert ? ~w_q : w_q;
    // Dither bias is applied upstream, so the low bits are simply truncated.
    assign w_unused_lsbs = ^i_p[PIX_W-BPP-1:0];

endmodule

// File: rtl/dither_pack.sv
// Quantizes 4-pixel beats to BPP bits each and packs them MSB-first into OUT_W-bit words.
module dither_pack
    import dither_pack_pkg::*;
#(
    parameter int unsigned BPP   = 1,
    parameter int unsigned OUT_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    dither_pack_if.slave bus
);

    localparam int unsigned CODE_W = PIX_PER_BEAT * BPP;
    localparam int unsigned BEATS  = OUT_W / CODE_W;
    localparam int unsigned ACC_W  = OUT_W - CODE_W;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SH_W   = $clog2(OUT_W);

    generate
        if (!bpp_legal(BPP)) begin : g_bad_bpp
            $error("dither_pack: BPP must be 1 or 2");
        end
        if (!out_w_legal(BPP, OUT_W)) begin : g_bad_out_w
            $error("dither_pack: OUT_W must be a multiple of 4*BPP and hold at least two beats");
        end
    endgenerate

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [OUT_W-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_complete;
    logic              w_pop;
    logic [CODE_W-1:0] w_code;
    logic [SH_W-1:0]   w_shift;
    logic [OUT_W-1:0]  w_word;

    for (genvar g = 0; g < int'(PIX_PER_BEAT); g++) begin : g_pix
        pix_quant #(.BPP(BPP)) u_quant (
            .i_p      (bus.in_data[BEAT_W-1-g*PIX_W -: PIX_W]),
            .i_invert (bus.invert),
            .o_q_c    (w_code[CODE_W-1-g*BPP -: BPP])
        );
    end

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_complete = w_accept && ((r_cnt == CNT_W'(BEATS - 1)) || bus.in_last);
    assign w_pop      = r_out_valid && bus.out_ready;

    // acc is zero above the filled beats, so shifting left-aligns a partial word with zero LSBs.
    assign w_shift = SH_W'((BEATS - 1 - 32'(r_cnt)) * CODE_W);
    assign w_word  = {r_acc, w_code} << w_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= (r_acc << CODE_W) | ACC_W'(w_code);
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            // A completing beat takes priority over a pop so back-to-back words leave no gap.
            if (w_complete) begin
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
                r_out_last  <= bus.in_last;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_dither_pack.sv
// Self-checking bench for dither_pack: directed vectors, corner sequences and a random scoreboard.
module tb_dither_pack;

    localparam int unsigned OUT_W = 32;

    typedef struct {
        int          k;
        logic [15:0] data;
        logic        inv;
        int          nbeats;
        logic        last;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          n_pass;
    int          n_total;
    int          pend [2][$];
    logic [32:0] expq [2][$];
    vec_t        vecs [9];

    dither_pack_if #(.OUT_W(OUT_W)) bus1 ();
    dither_pack_if #(.OUT_W(OUT_W)) bus2 ();

    dither_pack #(.BPP(1), .OUT_W(OUT_W)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    dither_pack #(.BPP(2), .OUT_W(OUT_W)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input int k, input logic v, input logic [15:0] d, input logic l,
                         input logic inv, input logic ordy);
        if (k == 0) begin
            bus1.in_valid = v; bus1.in_data = d; bus1.in_last = l;
            bus1.invert = inv; bus1.out_ready = ordy;
        end else begin
            bus2.in_valid = v; bus2.in_data = d; bus2.in_last = l;
            bus2.invert = inv; bus2.out_ready = ordy;
        end
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 16'hxxxx, 1'bx, 1'bx, 1'b1);
    endtask

    function automatic logic [32:0] out_word(input int k);
        return (k == 0) ? {bus1.out_last, bus1.out_data} : {bus2.out_last, bus2.out_data};
    endfunction

    function automatic logic out_vld(input int k);
        return (k == 0) ? bus1.out_valid : bus2.out_valid;
    endfunction

    function automatic logic in_rdy(input int k);
        return (k == 0) ? bus1.in_ready : bus2.in_ready;
    endfunction

    // Reference quantizer: threshold at mid-scale for 1 bit, divide by 4 for 2 bits.
    function automatic int quant(input int p, input int bpp, input bit inv);
        int q;
        q = (bpp == 1) ? ((p >= 8) ? 1 : 0) : (p / 4);
        if (inv) q = (1 << bpp) - 1 - q;
        return q;
    endfunction

    task automatic model_accept(input int k, input logic [15:0] d, input logic inv, input logic last);
        int bpp;
        logic [31:0] w;
        bpp = k + 1;
        for (int i = 0; i < 4; i++) pend[k].push_back(quant(int'(d[15-4*i -: 4]), bpp, inv));
        if ((pend[k].size() * bpp >= 32) || last) begin
            w = '0;
            for (int i = 0; i < pend[k].size(); i++)
                w |= 32'(pend[k][i]) << (32 - bpp * (i + 1));
            expq[k].push_back({last, w});
            pend[k].delete();
        end
    endtask

    task automatic observe(input int k);
        logic iv, ir, il, inv, ov, ordy;
        logic [15:0] d;
        logic [32:0] w, e;
        if (k == 0) begin
            iv = bus1.in_valid; ir = bus1.in_ready; il = bus1.in_last; inv = bus1.invert;
            d = bus1.in_data; ov = bus1.out_valid; ordy = bus1.out_ready;
        end else begin
            iv = bus2.in_valid; ir = bus2.in_ready; il = bus2.in_last; inv = bus2.invert;
            d = bus2.in_data; ov = bus2.out_valid; ordy = bus2.out_ready;
        end
        w = out_word(k);
        if (ov && ordy) begin
            n_total++;
            if (expq[k].size() == 0) begin
                $display("FAIL sb_word dut%0d: got %h, expected no word", k, w);
            end else begin
                e = expq[k].pop_front();
                if (w === e) n_pass++;
                else $display("FAIL sb_word dut%0d: got %h, expected %h", k, w, e);
            end
        end
        if (iv && ir) model_accept(k, d, inv, il);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int early;
        early = 0;
        for (int b = 0; b < v.nbeats; b++) begin
            @(negedge clk);
            if (out_vld(v.k)) early++;
            drive(v.k, 1'b1, v.data, (b == v.nbeats - 1) ? v.last : 1'b0, v.inv, 1'b1);
        end
        @(negedge clk);
        idle(v.k);
        check($sformatf("vec%0d_early", n), 33'(early), 33'd0);
        check($sformatf("vec%0d_word", n), out_word(v.k), {v.exp_last, v.exp_data});
        check($sformatf("vec%0d_valid", n), 33'(out_vld(v.k)), 33'd1);
        @(negedge clk);
        check($sformatf("vec%0d_popped", n), 33'(out_vld(v.k)), 33'd0);
    endtask

    initial begin
        int early;
        n_pass  = 0;
        n_total = 0;
        vecs[0] = '{0, 16'hF0F0, 1'b0, 8, 1'b0, 32'hAAAAAAAA, 1'b0};
        vecs[1] = '{0, 16'h8787, 1'b0, 8, 1'b0, 32'hAAAAAAAA, 1'b0};
        vecs[2] = '{0, 16'h8787, 1'b1, 8, 1'b0, 32'h55555555, 1'b0};
        vecs[3] = '{1, 16'hC840, 1'b0, 4, 1'b0, 32'hE4E4E4E4, 1'b0};
        vecs[4] = '{0, 16'hFFFF, 1'b0, 3, 1'b1, 32'hFFF00000, 1'b1};
        vecs[5] = '{0, 16'hFFFF, 1'b0, 1, 1'b1, 32'hF0000000, 1'b1};
        vecs[6] = '{1, 16'hFFFF, 1'b0, 2, 1'b1, 32'hFFFF0000, 1'b1};
        vecs[7] = '{1, 16'h1234, 1'b1, 4, 1'b0, 32'hFEFEFEFE, 1'b0};
        vecs[8] = '{0, 16'h0000, 1'b1, 8, 1'b0, 32'hFFFFFFFF, 1'b0};

        // Power-on reset
        rst_n = 1'b1;
        idle(0);
        idle(1);
        #2 rst_n = 1'b0;
        #2;
        check("rst_word_dut1", out_word(0), 33'd0);
        check("rst_valid_dut1", 33'(out_vld(0)), 33'd0);
        check("rst_ready_dut1", 33'(in_rdy(0)), 33'd1);
        check("rst_valid_dut2", 33'(out_vld(1)), 33'd0);
        check("rst_ready_dut2", 33'(in_rdy(1)), 33'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_ready_dut1", 33'(in_rdy(0)), 33'd1);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Backpressure: word held while out_ready=0, then pop and a completing beat together
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            drive(0, 1'b1, 16'hF0F0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("bp_ready_c%0d", c), 33'(in_rdy(0)), 33'd0);
            check($sformatf("bp_hold_c%0d", c), {out_vld(0), out_word(0)} >> 0 & 33'h1FFFFFFFF,
                  {1'b0, 32'hAAAAAAAA});
            @(negedge clk);
        end
        drive(0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        #1 check("bp_release_ready", 33'(in_rdy(0)), 33'd1);
        @(negedge clk);
        idle(0);
        check("bp_next_valid", 33'(out_vld(0)), 33'd1);
        check("bp_next_word", out_word(0), {1'b1, 32'hF0000000});
        @(negedge clk);
        check("bp_no_dup", 33'(out_vld(0)), 33'd0);

        // Asynchronous reset in the middle of a word
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            drive(0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        idle(0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_word", out_word(0), 33'd0);
        check("mid_rst_valid", 33'(out_vld(0)), 33'd0);
        check("mid_rst_ready", 33'(in_rdy(0)), 33'd1);
        @(negedge clk);
        check("mid_rst_hold", out_word(0), 33'd0);
        @(negedge clk);
        rst_n = 1'b1;
        early = 0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            if (out_vld(0)) early++;
            drive(0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        idle(0);
        check("mid_rst_early", 33'(early), 33'd0);
        check("mid_rst_word_after", out_word(0), 33'd0);
        check("mid_rst_valid_after", 33'(out_vld(0)), 33'd1);
        @(negedge clk);
        check("mid_rst_single", 33'(out_vld(0)), 33'd0);

        // Random traffic against the reference model
        for (int k = 0; k < 2; k++) begin
            pend[k].delete();
            expq[k].delete();
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                drive(k, 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 7) == 0),
                      1'($urandom), 1'($urandom_range(0, 2) != 0));
            #1;
            observe(0);
            observe(1);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            idle(0);
            idle(1);
            #1;
            observe(0);
            observe(1);
        end
        check("sb_drain_dut1", 33'(expq[0].size()), 33'd0);
        check("sb_drain_dut2", 33'(expq[1].size()), 33'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
